// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one combinational function unit between two requesters.
// Operands are held stable for EXEC_CYCLES cycles so the unit's paths can be treated as multicycle.
module fu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  fs0,
    input  logic [3:0]  fs1,
    input  logic [15:0] opa0,
    input  logic [15:0] opa1,
    input  logic [15:0] opb0,
    input  logic [15:0] opb1,
    output logic        ack0,
    output logic        ack1,
    output logic [3:0]  fu_fs,
    output logic [15:0] fu_opa,
    output logic [15:0] fu_opb,
    input  logic [15:0] fu_result,
    input  logic        fu_v,
    input  logic        fu_c,
    input  logic        fu_n,
    input  logic        fu_z,
    output logic [15:0] result,
    output logic        v,
    output logic        c,
    output logic        n,
    output logic        z,
    output logic        err,
    output logic        done,
    output logic        done_id,
    output logic        busy,
    output logic        ovf_sticky,
    input  logic        clr_sticky
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned FS_W     = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned EXEC_EFF = (EXEC_CYCLES == 0) ? 1 : EXEC_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(EXEC_EFF - 1);
    localparam logic [FS_W-1:0]  FS_ILLEGAL_MIN = FS_W'(13);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             gnt_id;
    logic             grant_c;
    logic             win_c;
    logic             capture_c;
    logic             illegal_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = EXEC;
            EXEC:    if (cnt == '0)    state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes; with both requesting, the priority pointer picks the winner
    always_comb begin
        grant_c   = 1'b0;
        win_c     = 1'b0;
        capture_c = 1'b0;
        illegal_c = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            grant_c = 1'b1;
            win_c   = (req0 && req1) ? ptr : req1;
        end
        if (state == CAPTURE) begin
            capture_c = 1'b1;
            illegal_c = (fu_fs >= FS_ILLEGAL_MIN);
        end
    end

    // Grant side: operand latch, acks, pointer and hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_fs  <= '0;
            fu_opa <= '0;
            fu_opb <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ptr    <= 1'b0;
            gnt_id <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            ack0 <= grant_c && !win_c;
            ack1 <= grant_c && win_c;
            busy <= (state_nxt != IDLE);
            if (grant_c) begin
                fu_fs  <= win_c ? fs1  : fs0;
                fu_opa <= win_c ? opa1 : opa0;
                fu_opb <= win_c ? opb1 : opb0;
                ptr    <= !win_c;
                gnt_id <= win_c;
                cnt    <= CNT_LOAD;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Capture side: result, flags, done pulse and overflow sticky (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            v          <= 1'b0;
            c          <= 1'b0;
            n          <= 1'b0;
            z          <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            done <= capture_c;
            if (capture_c) begin
                done_id <= gnt_id;
                err     <= illegal_c;
                if (illegal_c) begin
                    result <= DATA_W'(0);
                    v      <= 1'b0;
                    c      <= 1'b0;
                    n      <= 1'b0;
                    z      <= 1'b1;
                end else begin
                    result <= fu_result;
                    v      <= fu_v;
                    c      <= fu_c;
                    n      <= fu_n;
                    z      <= fu_z;
                end
            end
            if (capture_c && fu_v && !illegal_c) ovf_sticky <= 1'b1;
            else if (clr_sticky)                 ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/fu_arbiter.md
Name: fu_arbiter

Overview:
- Shares one function_unit instance between two requesters (port 0 and port 1) using round-robin arbitration.
- Latches the winning opcode and operands, then holds them stable on the function-unit inputs for a programmable number of cycles, so the long ripple and mult8 paths are multicycle.
- Registers result, V/C/N/Z and an error flag, and returns them with a done pulse tagged by requester id.
- Sits between the instruction-issue logic and the combinational function unit.

Parameters:
- EXEC_CYCLES, 2, cycles the function-unit inputs are held before capture. Legal range 1..15; counter is 4 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  request from requester 0 / 1
- fs0, fs1  in  4  function select for requester 0 / 1
- opa0, opa1  in  16  operand A for requester 0 / 1
- opb0, opb1  in  16  operand B for requester 0 / 1
- ack0, ack1  out  1  registered one-cycle acceptance pulse
- fu_fs  out  4  to function unit FS; registered
- fu_opa, fu_opb  out  16  to function unit OpA / OpB; registered
- fu_result  in  16  from function unit result
- fu_v, fu_c, fu_n, fu_z  in  1  from function unit status bits
- result  out  16  captured result
- v, c, n, z  out  1  captured status bits
- err  out  1  captured illegal-opcode flag
- done  out  1  one-cycle pulse: result, flags and done_id valid
- done_id  out  1  requester that owns the current done
- busy  out  1  high while state is not IDLE
- ovf_sticky  out  1  set on any capture with V=1
- clr_sticky  in  1  synchronous clear for ovf_sticky

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all outputs 0; priority pointer=0; counter=0. A transaction in flight is discarded: no done, no ack.
- States: IDLE, EXEC, CAPTURE.
- IDLE, no request: remain in IDLE.
- IDLE, request present:
  - Winner: if only one req is high, that port wins. If both are high, the port equal to the priority pointer wins.
  - At the edge: latch winner's fs/opa/opb into fu_fs/fu_opa/fu_opb; ackX=1 for the next cycle only; counter=EXEC_CYCLES-1; pointer=other port; grant id latched; go to EXEC.
- EXEC: fu_* inputs held constant. If counter==0, go to CAPTURE; otherwise decrement the counter.
- CAPTURE edge:
  - result<=fu_result; v,c,n,z<=fu_*; done_id<=grant id; done=1 for the following cycle only; go to IDLE.
  - If fu_fs is in 1101..1111: err=1, result=0, v=c=n=0, z=1. Otherwise err=0.
- Latency: req sampled high in IDLE at cycle 0 -> ack in cycle 1 -> done in cycle EXEC_CYCLES+2. A new grant can be made at the edge ending the done cycle.
- Requester handshake:
  - Requester holds req and operands until it sees ack, then drops or changes them.
  - req sampled in non-IDLE states is ignored; no queuing.
  - A requester holding req continuously is re-granted only after the other port gets priority. This prevents starvation when both requesters are active.
- Output persistence: result/v/c/n/z/err/done_id hold their values until the next CAPTURE.
- ovf_sticky:
  - Set at a CAPTURE edge where fu_v=1 and the opcode is legal.
  - Cleared at any edge with clr_sticky=1.
  - Simultaneous set and clear: set wins.
- Out-of-range parameter: EXEC_CYCLES=0 is treated as 1.
- fu_* outputs are never changed outside the IDLE->EXEC edge. This is what allows timing to treat the paths as multicycle.

Test Plan:
- req0, fs0=1000, opa0=7FFF, opb0=0001 -> ack0 in cycle 1; done in cycle 4 with result=8000, v=1, n=1, c=0, z=0, done_id=0; ovf_sticky=1.
- req1, fs1=1001, opa1=0005, opb1=0005 -> result=0000, z=1, c=1, v=0, done_id=1; ovf_sticky unchanged.
- req0 and req1 both held high from reset, both with fs=0110 and opb=0003 -> grants alternate 0,1,0,1; each result=0018; done_id sequence 0,1,0,1.
- req0 with fs0=1101 -> err=1, result=0000, z=1; next legal op (fs=0000, opa=1234) -> err=0, result=1234.
- rst_n pulsed low during EXEC -> outputs immediately 0; no done afterwards; the next request is granted to port 0 when both are requesting.
- ovf_sticky=1 with clr_sticky asserted at the same CAPTURE edge as another V=1 result -> ovf_sticky stays 1. clr_sticky alone -> ovf_sticky=0 at the next edge.
